// File: rtl/knn_selector_if.sv
// ---------------------------------------------------------------------------
// knn_selector_if
// Groups the sample stream and result signals of the k-nearest-neighbour
// selector into one bundle.
//   start        : one-cycle pulse that begins a new classification
//   in_valid     : distance/data_type/last are valid this cycle
//   in_ready     : sample accepted when in_valid and in_ready are both high
//   distance     : unsigned distance from the upstream distance stage
//   data_type    : class label paired with distance
//   last         : marks the final training sample of the classification
//   busy         : high whenever the selector is not idle
//   result_valid : one-cycle strobe when the result is ready
//   result_type  : winning class label (held until the next result)
//   result_count : number of votes for the winner (held until the next result)
// The master modport is the upstream producer, the slave modport is the
// selector itself.
// ---------------------------------------------------------------------------
interface knn_selector_if #(
  parameter int B = 8,
  parameter int K = 3
);
  localparam int CW = $clog2(K + 1);

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [B-1:0]  distance;
  logic [B-1:0]  data_type;
  logic          last;
  logic          busy;
  logic          result_valid;
  logic [B-1:0]  result_type;
  logic [CW-1:0] result_count;

  modport master (
    output start, in_valid, distance, data_type, last,
    input  in_ready, busy, result_valid, result_type, result_count
  );

  modport slave (
    input  start, in_valid, distance, data_type, last,
    output in_ready, busy, result_valid, result_type, result_count
  );
endinterface

// File: rtl/knn_selector.sv
// ---------------------------------------------------------------------------
// knn_selector
// Keeps the K nearest (distance, type) samples of a classification in a list
// sorted by ascending distance, then runs a K-cycle majority vote over the
// list and reports the winning class and its vote count.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, overrides every input
//   bus  : knn_selector_if slave modport (sample stream in, result out)
// Parameters: B = width of distance and class label, K = neighbours kept.
// ---------------------------------------------------------------------------
module knn_selector #(
  parameter int B = 8,
  parameter int K = 3
) (
  input logic           clk,
  input logic           rst,
  knn_selector_if.slave bus
);
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, VOTE, DONE} state_e;

  state_e        state_q, state_d;
  logic [B-1:0]  dist_q [K];
  logic [B-1:0]  dist_d [K];
  logic [B-1:0]  type_q [K];
  logic [B-1:0]  type_d [K];
  logic [K-1:0]  valid_q, valid_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] voteIdx_q, voteIdx_d;
  logic [B-1:0]  bestType_q, bestType_d;
  logic [CW-1:0] bestCount_q, bestCount_d;
  logic [B-1:0]  resultType_q, resultType_d;
  logic [CW-1:0] resultCount_q, resultCount_d;

  logic [CW-1:0] insPos;
  logic [B-1:0]  candType;
  logic          candValid;
  logic [CW-1:0] votes;
  logic          accept;

  assign accept = (state_q == COLLECT) && bus.in_valid;

  // Entries with distance <= the new one stay ahead of it, so equal
  // distances keep arrival order. Valid entries are always packed from
  // slot 0, so this count is also the slot index for the new sample; a
  // value of K means the sample falls off the end of the list.
  always_comb begin
    insPos = '0;
    for (int j = 0; j < K; j++) begin
      if (valid_q[j] && (dist_q[j] <= bus.distance)) begin
        insPos = insPos + CW'(1);
      end
    end
  end

  // The candidate for the current vote cycle is the slot at the vote index;
  // its vote total is how many valid slots share its label.
  always_comb begin
    candType  = '0;
    candValid = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (voteIdx_q == CW'(i)) begin
        candType  = type_q[i];
        candValid = valid_q[i];
      end
    end
    votes = '0;
    for (int j = 0; j < K; j++) begin
      if (valid_q[j] && (type_q[j] == candType)) begin
        votes = votes + CW'(1);
      end
    end
  end

  // Next-state logic for the FSM, the sorted list and the vote tracker.
  always_comb begin
    state_d       = state_q;
    dist_d        = dist_q;
    type_d        = type_q;
    valid_d       = valid_q;
    count_d       = count_q;
    voteIdx_d     = voteIdx_q;
    bestType_d    = bestType_q;
    bestCount_d   = bestCount_q;
    resultType_d  = resultType_q;
    resultCount_d = resultCount_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = COLLECT;
          valid_d = '0;
          count_d = '0;
        end
      end

      COLLECT: begin
        if (accept) begin
          // Slot insPos takes the new sample and everything behind it moves
          // down one; when insPos is K neither branch fires and the sample
          // is dropped.
          if (insPos == '0) begin
            dist_d[0]  = bus.distance;
            type_d[0]  = bus.data_type;
            valid_d[0] = 1'b1;
          end
          for (int j = 1; j < K; j++) begin
            if (CW'(j) == insPos) begin
              dist_d[j]  = bus.distance;
              type_d[j]  = bus.data_type;
              valid_d[j] = 1'b1;
            end else if (CW'(j) > insPos) begin
              dist_d[j]  = dist_q[j-1];
              type_d[j]  = type_q[j-1];
              valid_d[j] = valid_q[j-1];
            end
          end
          if (count_q != CW'(K)) begin
            count_d = count_q + CW'(1);
          end
          if (bus.last) begin
            state_d     = VOTE;
            voteIdx_d   = '0;
            bestType_d  = '0;
            bestCount_d = '0;
          end
        end
      end

      VOTE: begin
        // Strict comparison: on a tie the nearer first occurrence keeps it.
        if (candValid && (votes > bestCount_q)) begin
          bestType_d  = candType;
          bestCount_d = votes;
        end
        if (voteIdx_q == CW'(K - 1)) begin
          state_d       = DONE;
          resultType_d  = bestType_d;
          resultCount_d = bestCount_d;
        end else begin
          voteIdx_d = voteIdx_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset clears the FSM, the list and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      for (int j = 0; j < K; j++) begin
        dist_q[j] <= '0;
        type_q[j] <= '0;
      end
      valid_q       <= '0;
      count_q       <= '0;
      voteIdx_q     <= '0;
      bestType_q    <= '0;
      bestCount_q   <= '0;
      resultType_q  <= '0;
      resultCount_q <= '0;
    end else begin
      state_q       <= state_d;
      dist_q        <= dist_d;
      type_q        <= type_d;
      valid_q       <= valid_d;
      count_q       <= count_d;
      voteIdx_q     <= voteIdx_d;
      bestType_q    <= bestType_d;
      bestCount_q   <= bestCount_d;
      resultType_q  <= resultType_d;
      resultCount_q <= resultCount_d;
    end
  end

  assign bus.in_ready     = (state_q == COLLECT);
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result_type  = resultType_q;
  assign bus.result_count = resultCount_q;
endmodule

// File: tb/tb_knn_selector.sv
// ---------------------------------------------------------------------------
// tb_knn_selector
// Directed bench for knn_selector (K=3). A behavioural model keeps every
// accepted sample of the current classification, picks the K nearest by
// repeated minimum search (earliest arrival on ties) and counts votes over
// them; one compare process checks all outputs against it every cycle, and
// each scenario also checks hand-computed results.
// ---------------------------------------------------------------------------
module tb_knn_selector;
  localparam int B  = 8;
  localparam int K  = 3;
  localparam int CW = $clog2(K + 1);

  localparam logic [B-1:0] TA = 8'h0A;
  localparam logic [B-1:0] TB = 8'h0B;
  localparam logic [B-1:0] TC = 8'h0C;
  localparam logic [B-1:0] TD = 8'h0D;
  localparam logic [B-1:0] TE = 8'h0E;
  localparam logic [B-1:0] TX = 8'h58;
  localparam logic [B-1:0] TY = 8'h59;

  logic clk = 1'b0;
  logic rst;

  knn_selector_if #(.B(B), .K(K)) bus ();

  knn_selector #(.B(B), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  // Shared comparison: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Behavioural model of the selector's observable behaviour.
  typedef struct {
    logic [B-1:0] d;
    logic [B-1:0] t;
  } sample_t;

  typedef enum {M_IDLE, M_COLLECT, M_VOTE, M_DONE} mphase_e;

  sample_t       samples[$];
  mphase_e       phase = M_IDLE;
  int            voteLeft = 0;
  logic [B-1:0]  pendType = '0;
  logic [CW-1:0] pendCount = '0;
  logic [B-1:0]  expType = '0;
  logic [CW-1:0] expCount = '0;

  // Pick the K nearest samples (earliest arrival wins equal distances),
  // then the label with the most votes, nearest first occurrence on ties.
  function automatic void predict();
    int n;
    bit used[];
    logic [B-1:0] labels[$];
    n = samples.size();
    used = new[n];
    for (int k = 0; k < K && k < n; k++) begin
      int best;
      best = -1;
      for (int s = 0; s < n; s++) begin
        if (!used[s] && (best < 0 || samples[s].d < samples[best].d)) best = s;
      end
      used[best] = 1'b1;
      labels.push_back(samples[best].t);
    end
    pendType  = '0;
    pendCount = '0;
    for (int i = 0; i < labels.size(); i++) begin
      int v;
      v = 0;
      for (int j = 0; j < labels.size(); j++) begin
        if (labels[j] == labels[i]) v++;
      end
      if (v > int'(pendCount)) begin
        pendCount = CW'(v);
        pendType  = labels[i];
      end
    end
  endfunction

  // Model update on each rising edge from the inputs the DUT also sees.
  always @(posedge clk) begin
    if (rst) begin
      phase    = M_IDLE;
      samples.delete();
      expType  = '0;
      expCount = '0;
    end else begin
      case (phase)
        M_IDLE: begin
          if (bus.start) begin
            phase = M_COLLECT;
            samples.delete();
          end
        end
        M_COLLECT: begin
          if (bus.in_valid) begin
            sample_t s;
            s.d = bus.distance;
            s.t = bus.data_type;
            samples.push_back(s);
            if (bus.last) begin
              predict();
              phase    = M_VOTE;
              voteLeft = K;
            end
          end
        end
        M_VOTE: begin
          voteLeft--;
          if (voteLeft == 0) begin
            phase    = M_DONE;
            expType  = pendType;
            expCount = pendCount;
          end
        end
        M_DONE: phase = M_IDLE;
        default: phase = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy",         32'(bus.busy),         32'(phase != M_IDLE));
      checkOutput("in_ready",     32'(bus.in_ready),     32'(phase == M_COLLECT));
      checkOutput("result_valid", 32'(bus.result_valid), 32'(phase == M_DONE));
      checkOutput("result_type",  32'(bus.result_type),  32'(expType));
      checkOutput("result_count", 32'(bus.result_count), 32'(expCount));
    end
  end

  // Drive one sample for one cycle (inputs change just after the edge).
  task automatic applyStimulus(input logic [B-1:0] d, input logic [B-1:0] t,
                               input logic l);
    bus.in_valid  = 1'b1;
    bus.distance  = d;
    bus.data_type = t;
    bus.last      = l;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.last      = 1'b0;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Called right after the last sample is accepted; result_valid must rise
  // K+1 cycles after the cycle that carried last.
  task automatic waitResult(input string name, input logic [B-1:0] t,
                            input int c);
    int cycles;
    for (cycles = 1; cycles <= 20; cycles++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) break;
    end
    checkOutput({name, " latency"},    32'(cycles), 32'(K + 1));
    checkOutput({name, " type"},       32'(bus.result_type), 32'(t));
    checkOutput({name, " count"},      32'(bus.result_count), 32'(c));
    checkOutput({name, " model type"}, 32'(pendType), 32'(t));
    checkOutput({name, " model count"}, 32'(pendCount), 32'(c));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.distance  = '0;
    bus.data_type = '0;
    bus.last      = 1'b0;
    @(posedge clk); #1;
    checkEn = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("reset busy",     32'(bus.busy), 32'(0));
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'(0));
    checkOutput("reset type",     32'(bus.result_type), 32'(0));
    @(posedge clk); #1;

    // Majority over the three nearest: [(1,A),(2,B),(5,A)] -> A with 2.
    pulseStart();
    applyStimulus(8'd9, TA, 1'b0);
    applyStimulus(8'd2, TB, 1'b0);
    applyStimulus(8'd5, TA, 1'b0);
    applyStimulus(8'd7, TC, 1'b0);
    applyStimulus(8'd1, TA, 1'b1);
    waitResult("majority", TA, 2);

    // Equal distances keep arrival order, all single votes -> B wins.
    pulseStart();
    applyStimulus(8'd4, TB, 1'b0);
    applyStimulus(8'd4, TC, 1'b0);
    applyStimulus(8'd4, TD, 1'b1);
    waitResult("tie", TB, 1);

    // Full list [(1,A),(2,B),(3,B)]; (3,X) and (8,Y) must be dropped.
    pulseStart();
    applyStimulus(8'd1, TA, 1'b0);
    applyStimulus(8'd2, TB, 1'b0);
    applyStimulus(8'd3, TB, 1'b0);
    applyStimulus(8'd3, TX, 1'b0);
    applyStimulus(8'd8, TY, 1'b1);
    waitResult("full drop", TB, 2);

    // Single sample carrying last.
    pulseStart();
    applyStimulus(8'd0, TE, 1'b1);
    waitResult("single", TE, 1);

    // Reset while voting: outputs clear, then a fresh run is clean.
    pulseStart();
    applyStimulus(8'd6, TA, 1'b0);
    applyStimulus(8'd1, TB, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("vote reset busy",  32'(bus.busy), 32'(0));
    checkOutput("vote reset valid", 32'(bus.result_valid), 32'(0));
    checkOutput("vote reset type",  32'(bus.result_type), 32'(0));
    @(posedge clk); #1;
    pulseStart();
    applyStimulus(8'd6, TC, 1'b0);
    applyStimulus(8'd6, TD, 1'b0);
    applyStimulus(8'd2, TD, 1'b1);
    waitResult("after reset", TD, 2);

    // in_valid in IDLE is ignored; start in COLLECT must not clear the list.
    applyStimulus(8'd0, TC, 1'b0);
    pulseStart();
    applyStimulus(8'd1, TA, 1'b0);
    applyStimulus(8'd2, TA, 1'b0);
    pulseStart();
    applyStimulus(8'd3, TB, 1'b1);
    waitResult("ignored start", TA, 2);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/knn_selector.md
KNN_SELECTOR -- requirements
Module: knn_selector

Interface
REQ-001 Parameters SHALL be: B, default 8, bit width of distance and data_type; K, default 3, number of nearest neighbours retained (1..16).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-004 Port rst SHALL be: input, 1 bit, synchronous active-high reset.
REQ-005 Port start SHALL be: input, 1 bit, one-cycle pulse that begins a new classification.
REQ-006 Port in_valid SHALL be: input, 1 bit, distance/data_type/last are valid this cycle.
REQ-007 Port in_ready SHALL be: output, 1 bit, sample is accepted when in_valid and in_ready are both high.
REQ-008 Port distance SHALL be: input, B bits, unsigned distance produced by the upstream distance stage.
REQ-009 Port data_type SHALL be: input, B bits, class label paired with distance.
REQ-010 Port last SHALL be: input, 1 bit, marks the final training sample of the classification.
REQ-011 Port busy SHALL be: output, 1 bit, high in every state except IDLE.
REQ-012 Port result_valid SHALL be: output, 1 bit, high for exactly one cycle when the result is ready.
REQ-013 Port result_type SHALL be: output, B bits, winning class label.
REQ-014 Port result_count SHALL be: output, $clog2(K+1) bits, number of votes for the winner.

Function
REQ-015 The FSM SHALL have four states: IDLE, COLLECT, VOTE and DONE.
REQ-016 The FSM SHALL make these transitions: IDLE->COLLECT on start; COLLECT->VOTE on an accepted sample with last=1; VOTE->DONE after vote index K-1; DONE->IDLE after one cycle.
REQ-017 On entry to COLLECT, all list entries SHALL be invalidated and the entry count cleared.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 in_ready SHALL be 1 only in COLLECT, so throughput is one sample per cycle with no backpressure beyond state.
REQ-020 The list SHALL hold K (distance, type) entries sorted in ascending distance order; slot 0 is the nearest.
REQ-021 Insertion position for an accepted sample SHALL be the number of valid entries whose distance is <= the new distance, so equal distances keep arrival order (earlier sample wins).
REQ-022 Entries at and after the insertion position SHALL shift down one slot in the same cycle; the entry in slot K-1 is discarded.
REQ-023 With the list full and new distance >= slot K-1 distance, the sample SHALL be accepted and dropped with no list change.
REQ-024 The entry count SHALL saturate at K.
REQ-025 A sample accepted with last=1 SHALL be inserted before voting starts.
REQ-026 VOTE SHALL last exactly K cycles, index i = 0..K-1.
REQ-027 In cycle i, if slot i is valid, votes(i) SHALL be the number of valid slots whose type equals type[i].
REQ-028 A candidate SHALL replace the current best only if votes(i) > best_count (strict), so ties go to the candidate with the nearer first occurrence.
REQ-029 Invalid slots SHALL neither vote nor count.
REQ-030 In DONE, result_valid SHALL be 1, result_type = best type, and result_count = best count.
REQ-031 result_type and result_count SHALL hold their values until the next DONE.
REQ-032 If no samples were collected before last (i.e. last arrives on the first accepted sample, which is still inserted), the count SHALL be 1; an empty list is impossible.
REQ-033 Latency from acceptance of the last sample to result_valid SHALL be K+1 cycles.

Reset
REQ-034 rst SHALL take priority over all inputs, in any state including mid-COLLECT or mid-VOTE.
REQ-035 rst SHALL set the FSM to IDLE, invalidate all list entries, and clear the entry count, best_count, result_type (0), result_count (0), result_valid (0), busy (0) and in_ready (0).
REQ-036 After rst, a start pulse SHALL be required before any sample is accepted.

Verification
REQ-037 K=3: distances/types (9,A),(2,B),(5,A),(7,C),(1,A),last -> list [(1,A),(2,B),(5,A)], result_type=A, result_count=2, result_valid exactly 4 cycles after last.
REQ-038 K=3 tie: (4,B),(4,C),(4,D) last -> list order B,C,D, each with 1 vote, result_type=B, count=1.
REQ-039 K=3, full list [1,2,3], then sample (3,X) and (8,Y) -> both accepted and dropped, list unchanged.
REQ-040 Single sample (0,E) with last -> result_type=E, count=1.
REQ-041 rst asserted in VOTE -> next cycle busy=0, result_valid=0, result_type=0; following start plus samples produce a correct fresh result with no stale entries.
REQ-042 start pulsed during COLLECT, and in_valid asserted in IDLE -> both ignored (in_ready=0 in IDLE, list unaffected).
